// File: rtl/issue_ctrl.sv
// Instruction issue controller in front of the 5-stage pipeline.
// Queues 8-bit instructions from a valid/ready source, issues them in order
// to IF/ID, and inserts NOP bubbles (8'h00) while a source register still has
// a write in flight. The datapath has no bypassing, so the scoreboard keeps
// one small down-counter per register.
module issue_ctrl #(
    parameter int DEPTH      = 4,
    parameter int NREGS      = 4,
    parameter int HAZ_WINDOW = 4,
    parameter int CNT_W      = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [7:0]                 in_instr,
    output logic                       in_ready,
    input  logic                       hold,
    input  logic                       flush,
    output logic [7:0]                 issue_instr,
    output logic                       hazard,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic [CNT_W-1:0]           bubble_cnt
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = AW + 1;
    localparam int SBW = $clog2(HAZ_WINDOW + 1);

    logic [7:0]     mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic [CW-1:0]  count;
    logic [SBW-1:0] sb [NREGS];

    logic [7:0]     head;
    logic [2:0]     head_op;
    logic [1:0]     head_rd;
    logic [1:0]     head_rs2;
    logic           fifo_empty;
    logic           reads_rd;
    logic           reads_rs2;
    logic           writes_rd;
    logic           eligible;
    logic           issue_slot;
    logic           do_issue;
    logic           do_bubble;
    logic           push;

    assign head       = mem[rd_ptr];
    assign head_op    = head[6:4];
    assign head_rd    = head[3:2];
    assign head_rs2   = head[1:0];
    assign fifo_empty = (count == '0);

    // Operand usage of the head: NOP touches nothing, INC only reads rd/rs1,
    // ADD and every unknown opcode are treated as reading both fields.
    always_comb begin
        reads_rd  = 1'b0;
        reads_rs2 = 1'b0;
        writes_rd = 1'b0;
        if (head_op != 3'b000) begin
            reads_rd  = 1'b1;
            writes_rd = 1'b1;
            reads_rs2 = (head_op != 3'b011);
        end
    end

    // The head may issue once none of its source registers has a pending write;
    // its own destination counter is not consulted, so WAW simply reloads it.
    always_comb begin
        eligible = 1'b1;
        if (reads_rd && (sb[head_rd] != '0)) begin
            eligible = 1'b0;
        end
        if (reads_rs2 && (sb[head_rs2] != '0)) begin
            eligible = 1'b0;
        end
    end

    assign issue_slot = !flush && !hold && !fifo_empty;
    assign do_issue   = issue_slot && eligible;
    assign do_bubble  = issue_slot && !eligible;

    assign in_ready   = !reset && !flush && (count < CW'(DEPTH));
    assign push       = in_valid && in_ready;
    assign fifo_count = count;

    // Queue bookkeeping: flush empties it, otherwise push and pop may coincide.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_issue) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(do_issue);
        end
    end

    // Instruction storage; contents are only meaningful below count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_instr;
        end
    end

    // Scoreboard counters run down every cycle, including hold and flush,
    // because writes already in the pipeline still complete.
    always_ff @(posedge clk) begin
        for (int r = 0; r < NREGS; r++) begin
            if (reset) begin
                sb[r] <= '0;
            end else if (do_issue && writes_rd && (int'(head_rd) == r)) begin
                sb[r] <= SBW'(HAZ_WINDOW);
            end else if (sb[r] != '0) begin
                sb[r] <= sb[r] - 1'b1;
            end
        end
    end

    // Registered issue slot toward IF/ID, with the hazard flag for bubbles.
    always_ff @(posedge clk) begin
        if (reset) begin
            issue_instr <= 8'h00;
            hazard      <= 1'b0;
        end else if (flush) begin
            issue_instr <= 8'h00;
            hazard      <= 1'b0;
        end else if (hold) begin
            issue_instr <= issue_instr;
            hazard      <= hazard;
        end else if (fifo_empty) begin
            issue_instr <= 8'h00;
            hazard      <= 1'b0;
        end else if (!eligible) begin
            issue_instr <= 8'h00;
            hazard      <= 1'b1;
        end else begin
            issue_instr <= head;
            hazard      <= 1'b0;
        end
    end

    // Saturating count of hazard bubbles since reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt <= '0;
        end else if (do_bubble && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_issue_ctrl.sv
// Testbench for issue_ctrl: directed scenarios followed by random traffic,
// all compared against a queue-based reference model that tracks, per
// register, the edge at which its last producer issued.
module tb_issue_ctrl;

    localparam int DEPTH   = 4;
    // Narrow bubble counter so saturation is reachable in a few hundred cycles.
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int RAW_GAP = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic [7:0]       in_instr;
    logic             in_ready;
    logic             hold;
    logic             flush;
    logic [7:0]       issue_instr;
    logic             hazard;
    logic [2:0]       fifo_count;
    logic [CNT_W-1:0] bubble_cnt;

    int checks   = 0;
    int failures = 0;

    logic [7:0] q[$];
    logic [7:0] m_issue;
    logic       m_hazard;
    int         m_bcnt;
    int         last_wr[4];
    int         edge_n = 0;

    issue_ctrl #(
        .DEPTH(DEPTH),
        .NREGS(4),
        .HAZ_WINDOW(4),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_instr(in_instr),
        .in_ready(in_ready),
        .hold(hold),
        .flush(flush),
        .issue_instr(issue_instr),
        .hazard(hazard),
        .fifo_count(fifo_count),
        .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h exp=%0h at edge %0d", tag, got, exp, edge_n);
        end
    endtask

    // Reference model: a consumer may issue RAW_GAP edges after its producer.
    task automatic model_step(input logic rst, input logic fl, input logic hd,
                              input logic do_push, input logic [7:0] ins);
        logic [7:0] h;
        logic [2:0] op;
        bit         rd_used;
        bit         rs2_used;
        bit         ok;
        if (rst) begin
            q.delete();
            m_issue  = 8'h00;
            m_hazard = 1'b0;
            m_bcnt   = 0;
            for (int r = 0; r < 4; r++) last_wr[r] = -100;
        end else if (fl) begin
            q.delete();
            m_issue  = 8'h00;
            m_hazard = 1'b0;
        end else begin
            if (!hd) begin
                if (q.size() == 0) begin
                    m_issue  = 8'h00;
                    m_hazard = 1'b0;
                end else begin
                    h        = q[0];
                    op       = h[6:4];
                    rd_used  = (op != 3'd0);
                    rs2_used = (op != 3'd0) && (op != 3'd3);
                    ok = 1'b1;
                    if (rd_used && (edge_n - last_wr[h[3:2]] < RAW_GAP)) ok = 1'b0;
                    if (rs2_used && (edge_n - last_wr[h[1:0]] < RAW_GAP)) ok = 1'b0;
                    if (!ok) begin
                        m_issue  = 8'h00;
                        m_hazard = 1'b1;
                        if (m_bcnt < CNT_MAX) m_bcnt++;
                    end else begin
                        m_issue  = h;
                        m_hazard = 1'b0;
                        void'(q.pop_front());
                        if (op != 3'd0) last_wr[h[3:2]] = edge_n;
                    end
                end
            end
            if (do_push) q.push_back(ins);
        end
        edge_n++;
    endtask

    // Drives one cycle of inputs, checks in_ready, then checks registered outputs.
    task automatic applyStimulus(input logic rst, input logic fl, input logic hd,
                                 input logic vld, input logic [7:0] ins);
        logic exp_ready;
        reset    = rst;
        flush    = fl;
        hold     = hd;
        in_valid = vld;
        in_instr = ins;
        #1;
        exp_ready = !rst && !fl && (q.size() < DEPTH);
        checkOutput("in_ready", in_ready, exp_ready);
        @(posedge clk);
        model_step(rst, fl, hd, vld && exp_ready, ins);
        #1;
        checkOutput("issue_instr", issue_instr, m_issue);
        checkOutput("hazard", hazard, m_hazard);
        checkOutput("fifo_count", fifo_count, q.size());
        checkOutput("bubble_cnt", bubble_cnt, m_bcnt);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic push_one(input logic [7:0] ins);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, ins);
    endtask

    initial begin
        logic [7:0] t4_list[4];
        logic [7:0] r_ins;
        int         u;
        t4_list[0] = 8'h10;
        t4_list[1] = 8'h35;
        t4_list[2] = 8'h3A;
        t4_list[3] = 8'h3F;

        // T1: reset held two cycles
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("t1_issue", issue_instr, 8'h00);
        checkOutput("t1_count", fifo_count, 0);
        idle(1);

        // T2: independent INC R1 then ADD R0 issue on consecutive edges
        push_one(8'h34);
        push_one(8'h10);
        checkOutput("t2_first", issue_instr, 8'h34);
        idle(1);
        checkOutput("t2_second", issue_instr, 8'h10);
        idle(2);
        checkOutput("t2_bubbles", bubble_cnt, 0);

        // T3: back-to-back INC R1 gives exactly four hazard bubbles
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        push_one(8'h34);
        push_one(8'h34);
        idle(3);
        checkOutput("t3_mid_hazard", hazard, 1);
        idle(5);
        checkOutput("t3_bubbles", bubble_cnt, 4);

        // T4: fill under hold, then drain in push order
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, (i < 4) ? t4_list[i] : 8'h11);
        checkOutput("t4_full_count", fifo_count, 4);
        checkOutput("t4_full_ready", in_ready, 0);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            checkOutput("t4_order", issue_instr, t4_list[i]);
        end

        // T5: flush keeps the scoreboard, so a later consumer still waits
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        push_one(8'h34);
        push_one(8'h34);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("t5_flush_count", fifo_count, 0);
        checkOutput("t5_flush_issue", issue_instr, 8'h00);
        push_one(8'h34);
        idle(1);
        checkOutput("t5_wait", hazard, 1);
        idle(4);

        // T6: saturate the bubble counter, then reset while stalled
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 400; i++) push_one(8'h34);
        checkOutput("t6_saturated", bubble_cnt, CNT_MAX);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h34);
        checkOutput("t6_rst_issue", issue_instr, 8'h00);
        checkOutput("t6_rst_hazard", hazard, 0);
        checkOutput("t6_rst_bcnt", bubble_cnt, 0);
        checkOutput("t6_rst_count", fifo_count, 0);

        // Random traffic with occasional hold, flush and reset
        for (int i = 0; i < 3000; i++) begin
            r_ins      = 8'($urandom);
            u          = $urandom_range(0, 99);
            applyStimulus(u < 1, (u >= 1) && (u < 4), (u >= 4) && (u < 18),
                          ($urandom_range(0, 9) < 6), r_ins);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
